// File: rtl/rr_mux_arbiter.sv
// Round-robin arbiter for eight requesters sharing one 1-bit lane.
// It bounds each grantee's burst and registers the selected data bit with its source tag.
module rr_mux_arbiter #(
    parameter int HOLD_MAX = 16,
    parameter int CNT_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    input  logic [7:0] dat,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       grant_valid,
    output logic       out,
    output logic       out_valid,
    output logic [2:0] out_src
);

    // Handshake: grant_valid=1 means the requester at index sel owns the lane this cycle.
    // out_valid=1 means out/out_src carry the bit that the owner drove one cycle earlier.
    // No ready input exists; the consumer must accept every out_valid beat.
    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_MAX - 1);

    state_t           state;
    logic [CNT_W-1:0] hold_cnt;
    logic [2:0]       ptr;

    logic       release_now;
    logic [2:0] arb_base;
    logic [2:0] idx;
    logic [2:0] win;
    logic       win_found;

    // On release, the scan starts just past the owner, so the owner keeps only lowest priority.
    always_comb begin
        release_now = !req[sel] || (hold_cnt == LAST_CNT);
        arb_base    = (state == GRANT) ? sel + 3'd1 : ptr;
        idx         = '0;
        win         = '0;
        win_found   = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = arb_base + 3'(i);
            if (!win_found && req[idx]) begin
                win       = idx;
                win_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            hold_cnt    <= '0;
            ptr         <= '0;
            grant       <= '0;
            sel         <= '0;
            grant_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_found) begin
                        state       <= GRANT;
                        grant       <= 8'(1) << win;
                        sel         <= win;
                        grant_valid <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                GRANT: begin
                    if (!release_now) begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end else begin
                        ptr <= sel + 3'd1;
                        if (win_found) begin
                            grant    <= 8'(1) << win;
                            sel      <= win;
                            hold_cnt <= '0;
                        end else begin
                            state       <= IDLE;
                            grant       <= '0;
                            grant_valid <= 1'b0;
                            hold_cnt    <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= 1'b0;
            out_valid <= 1'b0;
            out_src   <= '0;
        end else begin
            out       <= dat[sel];
            out_valid <= grant_valid;
            out_src   <= sel;
        end
    end

endmodule
